// File: rtl/can_tx_scheduler_pkg.sv
// Shared CAN definitions: scheduler state encoding, mailbox geometry and
// the helper that extracts the 11-bit standard ID from mailbox bytes 0/1.
package can_defs;

    localparam int CAN_MB_BYTES = 10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_BUSY   = 3'd4
    } type_can_sched_states_e;

    function automatic logic [10:0] mb_id(input logic [7:0] b0, input logic [7:0] b1);
        return {b0, b1[7:5]};
    endfunction

endpackage

// File: rtl/can_prio_select.sv
// Combinational lowest-ID picker; ties resolve to the lowest mailbox index.
module can_prio_select
    import can_defs::*;
#(
    parameter int NUM_MB = 4
) (
    input  logic [NUM_MB-1:0][10:0]    ids,
    input  logic [NUM_MB-1:0]          pend,
    output logic [$clog2(NUM_MB)-1:0]  idx,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_MB);

    logic [10:0] best_s;

    // Ascending scan with strict compare keeps the lowest index on equal IDs
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        best_s = 11'h7ff;
        for (int i = 0; i < NUM_MB; i++) begin
            if (pend[i] && (!valid || (ids[i] < best_s))) begin
                valid  = 1'b1;
                idx    = IDX_W'(i);
                best_s = ids[i];
            end else begin
            end
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// Transmit mailbox scheduler in front of can_transmitter: lowest-ID
// arbitration between pending mailboxes, bounded retry and result reporting.
module can_tx_scheduler
    import can_defs::*;
#(
    parameter int NUM_MB    = 4,
    parameter int MAX_RETRY = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_point,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_MB)-1:0]  wr_mb,
    input  logic [3:0]                 wr_byte,
    input  logic [7:0]                 wr_data,
    input  logic [NUM_MB-1:0]          req_set,
    input  logic [NUM_MB-1:0]          abort,
    input  logic                       tx_done,
    input  logic                       arb_lost,
    output logic [7:0]                 tx_data_0,
    output logic [7:0]                 tx_data_1,
    output logic [7:0]                 tx_data_2,
    output logic [7:0]                 tx_data_3,
    output logic [7:0]                 tx_data_4,
    output logic [7:0]                 tx_data_5,
    output logic [7:0]                 tx_data_6,
    output logic [7:0]                 tx_data_7,
    output logic [7:0]                 tx_data_8,
    output logic [7:0]                 tx_data_9,
    output logic                       start_tx,
    output logic                       busy,
    output logic [NUM_MB-1:0]          pending,
    output logic                       tx_ok,
    output logic                       tx_fail,
    output logic [$clog2(NUM_MB)-1:0]  done_mb
);

    localparam int IDX_W = $clog2(NUM_MB);

    type_can_sched_states_e state_r, state_nxt_s;
    logic [7:0]             mb_mem_r [NUM_MB][CAN_MB_BYTES];
    logic [7:0]             tx_data_r [CAN_MB_BYTES];
    logic [NUM_MB-1:0]      pending_r, pending_nxt_s, sel_pend_s;
    logic [3:0]             retry_r [NUM_MB];
    logic [3:0]             retry_nxt_s [NUM_MB];
    logic [IDX_W-1:0]       act_mb_r, act_mb_nxt_s, done_mb_r, done_mb_nxt_s, sel_idx_s;
    logic                   lost_r, lost_nxt_s, abort_act_r, abort_act_nxt_s;
    logic                   tx_ok_r, tx_ok_nxt_s, tx_fail_r, tx_fail_nxt_s;
    logic                   start_tx_r, busy_r, sel_valid_s, active_s, lost_eff_s, abort_eff_s;
    logic [NUM_MB-1:0][10:0] ids_s;

    // Mailbox IDs for arbitration
    always_comb begin
        for (int i = 0; i < NUM_MB; i++) begin
            ids_s[i] = mb_id(mb_mem_r[i][0], mb_mem_r[i][1]);
        end
    end

    // A mailbox aborted in the select cycle must not win
    assign sel_pend_s = pending_r & ~abort;

    can_prio_select #(.NUM_MB(NUM_MB)) u_prio (
        .ids   (ids_s),
        .pend  (sel_pend_s),
        .idx   (sel_idx_s),
        .valid (sel_valid_s)
    );

    // Next-state, request bookkeeping and result resolution
    always_comb begin
        state_nxt_s     = state_r;
        pending_nxt_s   = pending_r;
        retry_nxt_s     = retry_r;
        act_mb_nxt_s    = act_mb_r;
        done_mb_nxt_s   = done_mb_r;
        lost_nxt_s      = lost_r;
        abort_act_nxt_s = abort_act_r;
        tx_ok_nxt_s     = 1'b0;
        tx_fail_nxt_s   = 1'b0;
        active_s        = (state_r == S_LOAD) || (state_r == S_START) || (state_r == S_BUSY);
        lost_eff_s      = lost_r | arb_lost;
        abort_eff_s     = abort_act_r | abort[act_mb_r];
        case (state_r)
            S_IDLE: state_nxt_s = S_IDLE;
            S_SELECT: begin
                if (sel_valid_s) begin
                    act_mb_nxt_s    = sel_idx_s;
                    lost_nxt_s      = 1'b0;
                    abort_act_nxt_s = 1'b0;
                    state_nxt_s     = S_LOAD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                abort_act_nxt_s = abort_eff_s;
                state_nxt_s     = S_START;
            end
            S_START: begin
                abort_act_nxt_s = abort_eff_s;
                if (sample_point) begin
                    state_nxt_s = S_BUSY;
                end else begin
                    state_nxt_s = S_START;
                end
            end
            S_BUSY: begin
                abort_act_nxt_s = abort_eff_s;
                lost_nxt_s      = lost_eff_s;
                if (tx_done) begin
                    state_nxt_s     = S_IDLE;
                    lost_nxt_s      = 1'b0;
                    abort_act_nxt_s = 1'b0;
                    done_mb_nxt_s   = act_mb_r;
                    if (abort_eff_s || !lost_eff_s) begin
                        pending_nxt_s[act_mb_r] = 1'b0;
                        retry_nxt_s[act_mb_r]   = 4'd0;
                        tx_ok_nxt_s             = !lost_eff_s;
                        tx_fail_nxt_s           = lost_eff_s;
                    end else if ((retry_r[act_mb_r] + 4'd1) == 4'(MAX_RETRY)) begin
                        pending_nxt_s[act_mb_r] = 1'b0;
                        retry_nxt_s[act_mb_r]   = 4'd0;
                        tx_fail_nxt_s           = 1'b1;
                    end else begin
                        retry_nxt_s[act_mb_r] = retry_r[act_mb_r] + 4'd1;
                    end
                end else begin
                    state_nxt_s = S_BUSY;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
        // Abort is applied after request so that it wins a same-cycle collision
        for (int i = 0; i < NUM_MB; i++) begin
            if (req_set[i]) begin
                pending_nxt_s[i] = 1'b1;
                retry_nxt_s[i]   = 4'd0;
            end else begin
            end
            if (abort[i] && !(active_s && (IDX_W'(i) == act_mb_r))) begin
                pending_nxt_s[i] = 1'b0;
            end else begin
            end
        end
        if (state_r == S_IDLE) begin
            if (|pending_nxt_s) begin
                state_nxt_s = S_SELECT;
            end else begin
                state_nxt_s = S_IDLE;
            end
        end else begin
        end
    end

    // Control and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            pending_r   <= '0;
            act_mb_r    <= '0;
            done_mb_r   <= '0;
            lost_r      <= 1'b0;
            abort_act_r <= 1'b0;
            tx_ok_r     <= 1'b0;
            tx_fail_r   <= 1'b0;
            start_tx_r  <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < NUM_MB; i++) begin
                retry_r[i] <= 4'd0;
            end
        end else begin
            state_r     <= state_nxt_s;
            pending_r   <= pending_nxt_s;
            act_mb_r    <= act_mb_nxt_s;
            done_mb_r   <= done_mb_nxt_s;
            lost_r      <= lost_nxt_s;
            abort_act_r <= abort_act_nxt_s;
            tx_ok_r     <= tx_ok_nxt_s;
            tx_fail_r   <= tx_fail_nxt_s;
            start_tx_r  <= (state_nxt_s == S_START);
            busy_r      <= (state_nxt_s == S_BUSY);
            retry_r     <= retry_nxt_s;
        end
    end

    // Mailbox storage; a pending mailbox is write-locked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_MB; i++) begin
                for (int k = 0; k < CAN_MB_BYTES; k++) begin
                    mb_mem_r[i][k] <= 8'd0;
                end
            end
        end else if (wr_en && (32'(wr_mb) < NUM_MB) && !pending_r[wr_mb] &&
                     (wr_byte < 4'(CAN_MB_BYTES))) begin
            mb_mem_r[wr_mb][wr_byte] <= wr_data;
        end else begin
        end
    end

    // Frame bytes presented to the transmitter, held until the next load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CAN_MB_BYTES; k++) begin
                tx_data_r[k] <= 8'd0;
            end
        end else if (state_r == S_LOAD) begin
            for (int k = 0; k < CAN_MB_BYTES; k++) begin
                tx_data_r[k] <= mb_mem_r[act_mb_r][k];
            end
        end else begin
        end
    end

    assign tx_data_0 = tx_data_r[0];
    assign tx_data_1 = tx_data_r[1];
    assign tx_data_2 = tx_data_r[2];
    assign tx_data_3 = tx_data_r[3];
    assign tx_data_4 = tx_data_r[4];
    assign tx_data_5 = tx_data_r[5];
    assign tx_data_6 = tx_data_r[6];
    assign tx_data_7 = tx_data_r[7];
    assign tx_data_8 = tx_data_r[8];
    assign tx_data_9 = tx_data_r[9];
    assign start_tx  = start_tx_r;
    assign busy      = busy_r;
    assign pending   = pending_r;
    assign tx_ok     = tx_ok_r;
    assign tx_fail   = tx_fail_r;
    assign done_mb   = done_mb_r;

endmodule
